// File: rtl/hazard_scoreboard.sv
// Data-hazard unit between ID and EXE: per-register latency scoreboard driving the ID stall,
// youngest-first operand forwarding selects for EXE, and a saturating stalled-cycle counter.
module hazard_scoreboard #(
    parameter int unsigned AW     = 5,
    parameter int unsigned STAGES = 2,
    parameter int unsigned LAT_W  = 3,
    parameter int unsigned CW     = 16,
    parameter int unsigned SW     = $clog2(STAGES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          id_rs,
    input  logic [AW-1:0]          id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic                   iss_valid,
    input  logic                   iss_we,
    input  logic [AW-1:0]          iss_rd,
    input  logic [LAT_W-1:0]       iss_lat,
    input  logic                   flush,
    input  logic [AW-1:0]          id_exe_rs,
    input  logic [AW-1:0]          id_exe_rt,
    input  logic [STAGES-1:0]      fwd_we,
    input  logic [STAGES*AW-1:0]   fwd_rd,
    output logic [SW-1:0]          forward_A,
    output logic [SW-1:0]          forward_B,
    output logic                   stall,
    output logic [(2**AW)-1:0]     busy_vec,
    output logic [CW-1:0]          stall_count
);

    localparam int unsigned NReg = 2 ** AW;

    logic [LAT_W-1:0] cnt_q [NReg];
    logic [LAT_W-1:0] cnt_d [NReg];
    logic [CW-1:0]    count_q, count_d;
    logic             issue;
    logic             rs_hazard, rt_hazard;
    logic [AW-1:0]    slot_rd [STAGES];

    always_comb begin
        for (int r = 0; r < int'(NReg); r++) begin
            busy_vec[r] = (cnt_q[r] != '0);
        end
    end

    // Register 0 never carries a hazard, so its busy bit is excluded explicitly.
    assign rs_hazard = id_use_rs && (id_rs != '0) && busy_vec[id_rs];
    assign rt_hazard = id_use_rt && (id_rt != '0) && busy_vec[id_rt];
    assign stall     = iss_valid && (rs_hazard || rt_hazard);
    assign issue     = iss_valid && !stall;

    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < int'(NReg); r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (issue && iss_we && (iss_rd == AW'(r)) && (iss_lat != '0)) begin
                cnt_d[r] = iss_lat;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (stall && (count_q != {CW{1'b1}})) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NReg); r++) begin
                cnt_q[r] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int r = 0; r < int'(NReg); r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            count_q <= count_d;
        end
    end

    assign stall_count = count_q;

    always_comb begin
        for (int i = 0; i < int'(STAGES); i++) begin
            slot_rd[i] = fwd_rd[i*AW +: AW];
        end
    end

    // Scan oldest to youngest so the youngest matching slot overwrites the select last.
    always_comb begin
        forward_A = '0;
        forward_B = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            if (fwd_we[i] && (slot_rd[i] != '0) && (slot_rd[i] == id_exe_rs)) begin
                forward_A = SW'(i + 1);
            end
            if (fwd_we[i] && (slot_rd[i] != '0) && (slot_rd[i] == id_exe_rt)) begin
                forward_B = SW'(i + 1);
            end
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data-hazard unit for the in-order MIPS-lite pipeline. It combines per-register scoreboard stall detection for multi-cycle producers (loads, mul/div) with N-source priority operand forwarding into EXE, plus a saturating stall counter. It sits between ID and EXE. It drives the ID stall and the two EXE operand-mux selects.

## Interface
Parameters:
- AW, 5, register-index width; 2**AW architectural registers, register 0 hardwired zero
- STAGES, 2, forwarding sources after EXE; slot 0 = EXE/MEM (youngest), slot 1 = MEM/WB, …
- LAT_W, 3, width of producer latency field / per-register counter
- CW, 16, width of stall-cycle counter
- SW, $clog2(STAGES+1), forward-select width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  AW  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1  instruction in ID actually reads rs / rt
- iss_valid  in  1  ID holds a valid instruction (pre-stall)
- iss_we, iss_rd  in  1, AW  ID instruction writes iss_rd
- iss_lat  in  LAT_W  cycles after issue before the result is forwardable; 0 = single-cycle ALU
- flush  in  1  pipeline flush (branch/exception)
- id_exe_rs, id_exe_rt  in  AW  source registers of the instruction in EXE
- fwd_we  in  STAGES  bit i: slot i writes back
- fwd_rd  in  STAGES*AW  slot i destination at [i*AW +: AW]
- forward_A, forward_B  out  SW  0 = register file, i+1 = forward from slot i
- stall  out  1  hold PC and IF/ID, bubble into EXE
- busy_vec  out  2**AW  bit r set while cnt[r]!=0
- stall_count  out  CW  saturating count of stalled cycles

## Operation
- Scoreboard: one LAT_W counter cnt[r] per register, r≥1; cnt[0] is constant 0.
- issue = iss_valid & ~stall. The block gates issue internally, so a stalled instruction never enters the scoreboard.
- Per cycle, per register r, priority order:
  - rst: cnt[r] ← 0.
  - flush: cnt[r] ← 0. Flush beats a same-cycle issue.
  - issue & iss_we & iss_rd==r & r≠0 & iss_lat≠0: cnt[r] ← iss_lat. On WAW the newer latency replaces the old value.
  - cnt[r]≠0: cnt[r] ← cnt[r]−1.
- stall (combinational from registered cnt and ID operands) = iss_valid & ((id_use_rs & id_rs≠0 & cnt[id_rs]≠0) | (id_use_rt & id_rt≠0 & cnt[id_rt]≠0)).
- Forwarding (combinational): forward_A = i+1 for the lowest i with fwd_we[i] & fwd_rd[i]≠0 & fwd_rd[i]==id_exe_rs; else 0. forward_B is identical using id_exe_rt.
  - Slot eligibility depends only on that slot's own fields.
  - The youngest matching slot always wins.
- stall_count increments by 1 each cycle stall=1. It holds at 2**CW−1. It is cleared only by rst; flush does not clear it.

## Timing
- Reset values: all cnt 0, busy_vec 0, stall_count 0. With inputs idle (iss_valid=0, fwd_we=0), stall=0 and forward_A=forward_B=0.
- Producer issuing in cycle t with latency L sets cnt=L at t+1. A dependent instruction in ID stalls during t+1 … t+L and issues at t+L+1.
- Load with L=1 gives exactly one bubble. The load data is then taken from the MEM/WB slot (forward select 2 with STAGES=2).
- stall, forward_A and forward_B have zero latency from their inputs. Only cnt and stall_count are registered.
- Issue and decrement are mutually exclusive for the same register in one cycle, because issue wins.
- Reset or flush mid-countdown: stall drops in the following cycle.

## Test plan
- Reset: hold rst 2 cycles with random inputs → busy_vec=0, stall_count=0. After release with idle inputs, stall=0 and forward_A=forward_B=0.
- Load-use: issue rd=8, iss_lat=1; next cycle ID has id_rs=8, id_use_rs=1 → stall=1 for exactly 1 cycle, then 0. stall_count=1.
- Multi-cycle: issue rd=3, iss_lat=4, then consumer reads rt=3 → 4 stall cycles. busy_vec[3] falls on the 4th stalled cycle's edge.
- Priority forwarding, STAGES=2:
  - fwd_we=2'b11, both fwd_rd=5, id_exe_rs=5 → forward_A=1.
  - fwd_we=2'b10 → forward_A=2.
  - fwd_rd[0]=5 with fwd_we[0]=0 and slot 1 matching → forward_A=2.
  - rd=0 anywhere → 0.
- Flush/WAW:
  - Issue rd=9, lat=5, then two cycles later issue rd=9, lat=2 → cnt reloads to 2.
  - Flush coincident with an issue of rd=7, lat=3 → busy_vec=0 next cycle and no stall on r7.
- Saturation: CW=4, force 20 consecutive stall cycles → stall_count=15 and holds.
